// File: rtl/regfile_pkg.sv
// Shared defaults, ABI register indices and the
// write-back priority select for the regfile_sb slice.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 1;
  localparam int REG_SP   = 2;
  localparam int REG_T0   = 5;

  typedef enum logic [1:0] {
    SEL_ARR = 2'd0,
    SEL_WB0 = 2'd1,
    SEL_WB1 = 2'd2
  } wb_sel_e;

  // wb0 (ALU) beats wb1 (load return) on a shared target
  function automatic wb_sel_e wb_sel(
    input logic hit0,
    input logic hit1
  );
    wb_sel_e s;
    s = SEL_ARR;
    if (hit0)      s = SEL_WB0;
    else if (hit1) s = SEL_WB1;
    return s;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Issue / write-back / read bundle between the
// pipeline (master) and the register file (slave).
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRP   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                wb0_en;
  logic [AW-1:0]       wb0_addr;
  logic [XLEN-1:0]     wb0_data;
  logic                wb1_en;
  logic [AW-1:0]       wb1_addr;
  logic [XLEN-1:0]     wb1_data;
  logic [NREGS-1:0]    busy_vec;
  logic                wrote_to_regfile;

  modport master (
    output rd_addr, issue_valid, issue_rd,
    output wb0_en, wb0_addr, wb0_data,
    output wb1_en, wb1_addr, wb1_data,
    input  rd_data, rd_busy,
    input  busy_vec, wrote_to_regfile
  );

  modport slave (
    input  rd_addr, issue_valid, issue_rd,
    input  wb0_en, wb0_addr, wb0_data,
    input  wb1_en, wb1_addr, wb1_data,
    output rd_data, rd_busy,
    output busy_vec, wrote_to_regfile
  );

endinterface

// File: rtl/regfile_fwd.sv
// One read port: write-back bypass mux and
// busy masking for same-cycle write-backs.
module regfile_fwd
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] arr_data,
  input  logic            arr_busy,
  input  logic            wb0_en,
  input  logic [AW-1:0]   wb0_addr,
  input  logic [XLEN-1:0] wb0_data,
  input  logic            wb1_en,
  input  logic [AW-1:0]   wb1_addr,
  input  logic [XLEN-1:0] wb1_data,
  output logic [XLEN-1:0] data,
  output logic            busy
);

  logic nz;
  logic hit0;
  logic hit1;

  assign nz   = |addr;
  assign hit0 = nz & wb0_en & (wb0_addr == addr);
  assign hit1 = nz & wb1_en & (wb1_addr == addr);

  // pick live write-back data over the array
  always_comb begin
    data = arr_data;
    unique case (wb_sel(hit0, hit1))
      SEL_WB0: data = wb0_data;
      SEL_WB1: data = wb1_data;
      default: data = arr_data;
    endcase
  end

  assign busy = arr_busy & ~(hit0 | hit1);

endmodule

// File: rtl/regfile_sb.sv
// Register file with busy-bit scoreboard,
// two write-back ports and per-port forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRP   = 2
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]           regs [NREGS];
  logic [NREGS-1:0]          busy;
  logic [NREGS-1:0]          busy_nxt;
  logic                      wrote;
  logic                      w0;
  logic                      w1;
  logic [NRP-1:0][XLEN-1:0]  rdata;
  logic [NRP-1:0]            rbusy;

  assign w0 = bus.wb0_en & (|bus.wb0_addr);
  assign w1 = bus.wb1_en & (|bus.wb1_addr);

  // array update; x0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        unique case (wb_sel(
          w0 && (bus.wb0_addr == AW'(r)),
          w1 && (bus.wb1_addr == AW'(r))))
          SEL_WB0: regs[r] <= bus.wb0_data;
          SEL_WB1: regs[r] <= bus.wb1_data;
          default: ;
        endcase
      end
    end
  end

  // scoreboard next state: new producer beats retiring one
  always_comb begin
    busy_nxt    = busy;
    busy_nxt[0] = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      if (bus.issue_valid &&
          bus.issue_rd == AW'(r))
        busy_nxt[r] = 1'b1;
      else if ((w0 && bus.wb0_addr == AW'(r)) ||
               (w1 && bus.wb1_addr == AW'(r)))
        busy_nxt[r] = 1'b0;
    end
  end

  // scoreboard and write pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= '0;
      wrote <= 1'b0;
    end else begin
      busy  <= busy_nxt;
      wrote <= w0 | w1;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rp
    logic [AW-1:0] a;
    assign a = bus.rd_addr[p*AW +: AW];

    regfile_fwd #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_fwd (
      .addr     (a),
      .arr_data (regs[a]),
      .arr_busy (busy[a]),
      .wb0_en   (bus.wb0_en),
      .wb0_addr (bus.wb0_addr),
      .wb0_data (bus.wb0_data),
      .wb1_en   (bus.wb1_en),
      .wb1_addr (bus.wb1_addr),
      .wb1_data (bus.wb1_data),
      .data     (rdata[p]),
      .busy     (rbusy[p])
    );
  end

  assign bus.rd_data          = rdata;
  assign bus.rd_busy          = rbusy;
  assign bus.busy_vec         = busy;
  assign bus.wrote_to_regfile = wrote;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table plus randomized run against
// a behavioural register-file model.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic clk;
  logic rst;

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NRP(2)) bus ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NRP(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, got, exp);
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        w0e;
    logic [4:0]  w0a;
    logic [31:0] w0d;
    logic        w1e;
    logic [4:0]  w1a;
    logic [31:0] w1d;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [31:0] ebv;
    logic        ew;
  } vec_t;

  function automatic vec_t mk(
    int iv, int ird, int w0e, int w0a,
    logic [31:0] w0d, int w1e, int w1a,
    logic [31:0] w1d, int r0, int r1,
    logic [31:0] e0, logic [31:0] e1,
    int eb, logic [31:0] ebv, int ew);
    vec_t v;
    v.iv  = 1'(iv);   v.ird = 5'(ird);
    v.w0e = 1'(w0e);  v.w0a = 5'(w0a);
    v.w0d = w0d;
    v.w1e = 1'(w1e);  v.w1a = 5'(w1a);
    v.w1d = w1d;
    v.r0  = 5'(r0);   v.r1  = 5'(r1);
    v.e0  = e0;       v.e1  = e1;
    v.eb  = 2'(eb);   v.ebv = ebv;
    v.ew  = 1'(ew);
    return v;
  endfunction

  task automatic drive(
    input logic iv, input logic [4:0] ird,
    input logic w0e, input logic [4:0] w0a,
    input logic [31:0] w0d,
    input logic w1e, input logic [4:0] w1a,
    input logic [31:0] w1d,
    input logic [4:0] r0, input logic [4:0] r1);
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    bus.wb0_en      = w0e;
    bus.wb0_addr    = w0a;
    bus.wb0_data    = w0d;
    bus.wb1_en      = w1e;
    bus.wb1_addr    = w1a;
    bus.wb1_data    = w1d;
    bus.rd_addr     = {r1, r0};
  endtask

  // behavioural model
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic        m_wrote;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy  = '0;
    m_wrote = 1'b0;
  endtask

  function automatic logic wb_hits(input logic [4:0] a);
    return a != 0 &&
      ((bus.wb0_en && bus.wb0_addr == a) ||
       (bus.wb1_en && bus.wb1_addr == a));
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return '0;
    if (bus.wb0_en && bus.wb0_addr == a) return bus.wb0_data;
    if (bus.wb1_en && bus.wb1_addr == a) return bus.wb1_data;
    return m_mem[a];
  endfunction

  function automatic logic m_rb(input logic [4:0] a);
    return m_busy[a] && !wb_hits(a);
  endfunction

  // clock edge: wb1 stored first so wb0 overwrites it
  task automatic m_edge();
    m_wrote = (bus.wb0_en && bus.wb0_addr != 0) ||
              (bus.wb1_en && bus.wb1_addr != 0);
    if (bus.wb1_en) m_mem[bus.wb1_addr] = bus.wb1_data;
    if (bus.wb0_en) m_mem[bus.wb0_addr] = bus.wb0_data;
    m_mem[0] = '0;
    if (bus.wb1_en) m_busy[bus.wb1_addr] = 1'b0;
    if (bus.wb0_en) m_busy[bus.wb0_addr] = 1'b0;
    if (bus.issue_valid) m_busy[bus.issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  vec_t tbl [14];

  initial begin
    logic [4:0] a0;
    logic [4:0] a1;

    tbl[0]  = mk(0,0, 1,REG_T0,32'hDEADBEEF, 0,0,0,
                 REG_T0,0, 32'hDEADBEEF,0, 0,0,0);
    tbl[1]  = mk(0,0, 0,0,0, 0,0,0,
                 5,7, 32'hDEADBEEF,0, 0,0,1);
    tbl[2]  = mk(0,0, 1,7,32'h11, 1,7,32'h22,
                 7,5, 32'h11,32'hDEADBEEF, 0,0,0);
    tbl[3]  = mk(0,0, 0,0,0, 0,0,0,
                 7,7, 32'h11,32'h11, 0,0,1);
    tbl[4]  = mk(1,3, 0,0,0, 0,0,0,
                 3,0, 0,0, 0,0,0);
    tbl[5]  = mk(0,0, 0,0,0, 0,0,0,
                 3,0, 0,0, 1,32'h8,0);
    tbl[6]  = mk(0,0, 0,0,0, 0,0,0,
                 3,3, 0,0, 3,32'h8,0);
    tbl[7]  = mk(0,0, 0,0,0, 1,3,32'h1234,
                 3,3, 32'h1234,32'h1234, 0,32'h8,0);
    tbl[8]  = mk(1,3, 1,3,32'h55, 0,0,0,
                 3,0, 32'h55,0, 0,0,1);
    tbl[9]  = mk(0,0, 0,0,0, 0,0,0,
                 3,3, 32'h55,32'h55, 3,32'h8,1);
    tbl[10] = mk(1,REG_ZERO, 1,0,32'hFFFFFFFF,
                 1,0,32'hAAAA,
                 0,3, 0,32'h55, 2,32'h8,0);
    tbl[11] = mk(0,0, 0,0,0, 0,0,0,
                 0,5, 0,32'hDEADBEEF, 0,32'h8,0);
    tbl[12] = mk(1,9, 0,0,0, 0,0,0,
                 9,0, 0,0, 0,32'h8,0);
    tbl[13] = mk(0,0, 0,0,0, 0,0,0,
                 9,3, 0,32'h55, 3,32'h208,0);

    rst = 1'b1;
    drive(0,0, 0,0,0, 0,0,0, 0,0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy_vec", 64'(bus.busy_vec), 0);
    chk("rst_wrote", 64'(bus.wrote_to_regfile), 0);
    rst = 1'b0;

    // every address on both ports reads zero, not busy
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = {5'(31 - a), 5'(a)};
      #1;
      chk("rst_rd0", 64'(bus.rd_data[31:0]), 0);
      chk("rst_rd1", 64'(bus.rd_data[63:32]), 0);
      chk("rst_rbusy", 64'(bus.rd_busy), 0);
    end
    chk("rst_wrote2", 64'(bus.wrote_to_regfile), 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].ird,
            tbl[i].w0e, tbl[i].w0a, tbl[i].w0d,
            tbl[i].w1e, tbl[i].w1a, tbl[i].w1d,
            tbl[i].r0, tbl[i].r1);
      #3;
      chk($sformatf("t%0d_rd0", i),
          64'(bus.rd_data[31:0]), 64'(tbl[i].e0));
      chk($sformatf("t%0d_rd1", i),
          64'(bus.rd_data[63:32]), 64'(tbl[i].e1));
      chk($sformatf("t%0d_rbusy", i),
          64'(bus.rd_busy), 64'(tbl[i].eb));
      chk($sformatf("t%0d_busy_vec", i),
          64'(bus.busy_vec), 64'(tbl[i].ebv));
      chk($sformatf("t%0d_wrote", i),
          64'(bus.wrote_to_regfile), 64'(tbl[i].ew));
      @(posedge clk);
      #1;
    end

    // asynchronous reset between edges while x9 busy
    drive(0,0, 0,0,0, 0,0,0, 9,REG_T0);
    #2;
    chk("pre_rst_busy_vec", 64'(bus.busy_vec), 64'h208);
    chk("pre_rst_rd1", 64'(bus.rd_data[63:32]),
        64'hDEADBEEF);
    rst = 1'b1;
    #1;
    chk("async_busy_vec", 64'(bus.busy_vec), 0);
    chk("async_wrote", 64'(bus.wrote_to_regfile), 0);
    chk("async_x9", 64'(bus.rd_data[31:0]), 0);
    chk("async_x9_busy", 64'(bus.rd_busy), 0);
    chk("async_x5", 64'(bus.rd_data[63:32]), 0);
    #2;
    rst = 1'b0;
    m_reset();

    // randomized traffic against the model
    @(posedge clk);
    #1;
    for (int c = 0; c < 400; c++) begin
      a0 = 5'($urandom_range(0, 7));
      a1 = 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom,
            a0, a1);
      #3;
      chk("rnd_rd0", 64'(bus.rd_data[31:0]), 64'(m_rd(a0)));
      chk("rnd_rd1", 64'(bus.rd_data[63:32]), 64'(m_rd(a1)));
      chk("rnd_rbusy", 64'(bus.rd_busy),
          64'({m_rb(a1), m_rb(a0)}));
      chk("rnd_busy_vec", 64'(bus.busy_vec), 64'(m_busy));
      chk("rnd_wrote", 64'(bus.wrote_to_regfile),
          64'(m_wrote));
      @(posedge clk);
      m_edge();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
